// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell
// plus a registered borrow. Start/done handshake; busy covers RUN and DONE.
// Optional signed overflow output is compiled in with SERIAL_SUB_SIGNED_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; diff/borrow_out hold the last result
// RUN    | one result bit per clock, WIDTH clocks in total
// DONE   | done pulse for one cycle, result valid, then back to IDLE

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ai, bi, d_bit, bout;

  // Full-subtractor cell on the current operand LSBs and the stored borrow.
  always_comb begin
    ai    = a_sh_q[0];
    bi    = b_sh_q[0];
    d_bit = ai ^ bi ^ bin_q;
    bout  = (~ai & bi) | (~(ai ^ bi) & bin_q);
  end

  // Next-state and datapath update; everything holds unless the FSM moves it.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = d_bit;
        bin_d             = bout;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_d == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      bin_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign diff       = res_q;
  assign borrow_out = bin_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef SERIAL_SUB_SIGNED_EN
  // The operand registers are shifted away during RUN, so the sign bits
  // are kept separately for the overflow decision at the last bit.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;

  // Capture sign bits on accept; resolve overflow on the final RUN edge,
  // where d_bit is the result MSB.
  always_comb begin
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (state_q == S_IDLE && start) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
    end
    if (state_q == S_RUN && state_d == S_DONE) begin
      ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end

  // Sign-bit and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=1 instances, directed
// vectors with literal expectations plus an arithmetic reference model
// checked every cycle at the falling edge.

module tb_serial_subtractor;

  localparam int W8 = 8;
  localparam int W1 = 1;

  typedef struct packed {
    logic [31:0] d;
    logic        b;
    logic        o;
  } res_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, diff8;
  logic       borrow8, busy8, done8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, diff1;
  logic       borrow1, busy1, done1;

`ifdef SERIAL_SUB_SIGNED_EN
  logic       ovf8, ovf1;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  serial_subtractor #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .diff(diff8), .borrow_out(borrow8), .busy(busy8), .done(done8)
`ifdef SERIAL_SUB_SIGNED_EN
    , .overflow(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(W1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .diff(diff1), .borrow_out(borrow1), .busy(busy1), .done(done1)
`ifdef SERIAL_SUB_SIGNED_EN
    , .overflow(ovf1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_sub(input int unsigned av, input int unsigned bv, input int w);
    res_t        r;
    int unsigned m;
    int          sa, sb, sr;
    m   = 32'd1 << w;
    r.d = (av + m - bv) % m;
    r.b = (av < bv);
    sa  = (av >= m / 2) ? int'(av) - int'(m) : int'(av);
    sb  = (bv >= m / 2) ? int'(bv) - int'(m) : int'(bv);
    sr  = sa - sb;
    r.o = (sr < -int'(m / 2)) || (sr > int'(m / 2) - 1);
    return r;
  endfunction

  // Timing model: rem counts cycles left in the operation; done when rem==1.
  int   m8_rem = 0, m1_rem = 0;
  res_t p8 = '0, p1 = '0, m8_r = '0, m1_r = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_rem <= 0;
      m8_r   <= '0;
    end else if (m8_rem == 0) begin
      if (start8 === 1'b1) begin
        p8     <= ref_sub(a8, b8, W8);
        m8_rem <= W8 + 1;
      end
    end else begin
      m8_rem <= m8_rem - 1;
      if (m8_rem == 2) m8_r <= p8;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m1_rem <= 0;
      m1_r   <= '0;
    end else if (m1_rem == 0) begin
      if (start1 === 1'b1) begin
        p1     <= ref_sub(a1, b1, W1);
        m1_rem <= W1 + 1;
      end
    end else begin
      m1_rem <= m1_rem - 1;
      if (m1_rem == 2) m1_r <= p1;
    end
  end

  // Per-cycle compare against the model; result checked outside RUN.
  always @(negedge clk) begin
    if (!rst) begin
      chk("m8_busy", busy8, m8_rem != 0);
      chk("m8_done", done8, m8_rem == 1);
      if (m8_rem <= 1) begin
        chk("m8_diff", diff8, m8_r.d);
        chk("m8_borrow", borrow8, m8_r.b);
`ifdef SERIAL_SUB_SIGNED_EN
        chk("m8_ovf", ovf8, m8_r.o);
`endif
      end
      chk("m1_busy", busy1, m1_rem != 0);
      chk("m1_done", done1, m1_rem == 1);
      if (m1_rem <= 1) begin
        chk("m1_diff", diff1, m1_r.d);
        chk("m1_borrow", borrow1, m1_r.b);
`ifdef SERIAL_SUB_SIGNED_EN
        chk("m1_ovf", ovf1, m1_r.o);
`endif
      end
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] ed,
                     input logic eb, input logic eo, input string nm);
    int cyc, bcnt;
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    cyc = 1; bcnt = 0;
    while (done8 !== 1'b1 && cyc < 30) begin
      if (busy8 === 1'b1) bcnt++;
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 9);
    chk({nm, "_diff"}, diff8, ed);
    chk({nm, "_borrow"}, borrow8, eb);
`ifdef SERIAL_SUB_SIGNED_EN
    chk({nm, "_ovf"}, ovf8, eo);
`endif
    if (busy8 === 1'b1) bcnt++;
    @(posedge clk); #1;
    chk({nm, "_busy_cycles"}, bcnt, 9);
    chk({nm, "_idle_after"}, {busy8, done8}, 2'b00);
  endtask

  task automatic op1(input logic ta, input logic tb, input logic ed, input logic eb,
                     input logic eo, input string nm);
    int cyc;
    a1 = ta; b1 = tb; start1 = 1'b1;
    @(posedge clk); #2;
    start1 = 1'b0;
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, cyc, 2);
    chk({nm, "_diff"}, diff1, ed);
    chk({nm, "_borrow"}, borrow1, eb);
`ifdef SERIAL_SUB_SIGNED_EN
    chk({nm, "_ovf"}, ovf1, eo);
`endif
    @(posedge clk); #1;
  endtask

  // {diff, borrow, overflow} for (a,b) = 00, 01, 10, 11
  logic [2:0] tt1 [4] = '{3'b000, 3'b111, 3'b100, 3'b000};

  initial begin
    int dcount, cyc;
    #1 rst = 1'b1;
    #1;
    chk("rst_diff8", diff8, 0);
    chk("rst_borrow8", borrow8, 0);
    chk("rst_busy_done8", {busy8, done8}, 0);
    chk("rst_diff1", diff1, 0);
`ifdef SERIAL_SUB_SIGNED_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    op8(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, "sub_5a_3c");
    op8(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, "sub_00_01");
    op8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    op8(8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, "sub_ff_00");

    // start held high through RUN with different operands: ignored
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(posedge clk); #2;
    a8 = 8'hFF; b8 = 8'hFF;
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_latency", cyc, 9);
    chk("hold_diff", diff8, 8'h0F);
    chk("hold_borrow", borrow8, 0);
    start8 = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dcount++;
    end
    chk("hold_extra_done", dcount, 0);
    chk("hold_busy_after", busy8, 0);

    // asynchronous reset four cycles into RUN
    a8 = 8'h5A; b8 = 8'hA5; start8 = 1'b1;
    @(posedge clk); #2;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_diff", diff8, 0);
    chk("abort_borrow", borrow8, 0);
    chk("abort_busy_done", {busy8, done8}, 0);
`ifdef SERIAL_SUB_SIGNED_EN
    chk("abort_ovf", ovf8, 0);
`endif
    @(posedge clk); #2 rst = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    op8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_03_05");

    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      logic [2:0] e;
      ab = 2'(i);
      e  = tt1[i];
      op1(ab[1], ab[0], e[2], e[1], e[0], $sformatf("w1_%0d%0d", ab[1], ab[0]));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial subtractor: computes `diff = a - b` over `WIDTH` bits, one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It generalises the combinational half-subtractor cell to arbitrary width with a start/done handshake. It serves as the area-minimal subtraction unit for sequential datapaths in the adders & subtractors family.

## Interface
- `WIDTH`, default 8, operand and result width in bits (legal range ≥ 1)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `start`  input  1  request to begin an operation; sampled only in IDLE
- `a`  input  WIDTH  minuend, captured on accepted `start`
- `b`  input  WIDTH  subtrahend, captured on accepted `start`
- `diff`  output  WIDTH  difference `a - b` mod 2^WIDTH
- `borrow_out`  output  1  final borrow; 1 when a < b unsigned
- `busy`  output  1  high while an operation is in progress
- `done`  output  1  single-cycle pulse when the result is valid
- `overflow`  output  1  signed overflow; present only with `SERIAL_SUB_SIGNED_EN`

## Operation
- One clock. Reset is asynchronous and active-high.
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: `diff`=0, `borrow_out`=0, `busy`=0, `done`=0, `overflow`=0, internal shift registers, borrow FF and bit counter all 0.
- IDLE: on edge with `start`=1, load `a`,`b` into shift registers, clear borrow FF and counter, → RUN. With `start`=0, stay. Outputs hold their last values.
- RUN, per edge:
  - Take LSBs `ai`,`bi` and borrow FF `bin`.
  - `d = ai ^ bi ^ bin`.
  - `bout = (~ai & bi) | (~(ai ^ bi) & bin)`.
  - Shift both operand registers right by 1. Shift `d` into the result register from the MSB side. Borrow FF ← `bout`. Counter +1.
  - On the edge where the counter reaches WIDTH, → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE unconditionally.
- `diff` and `borrow_out` are valid from the DONE cycle until the next accepted `start`. During RUN, `diff` shows partial shift contents and is undefined for checking.
- `busy`=1 in RUN and DONE, 0 in IDLE.
- `start` in RUN or DONE is ignored; it is not queued. `a`/`b` changes after capture have no effect.
- Reset asserted mid-operation aborts immediately. All outputs return to reset values and no `done` is issued.
- WIDTH=1: one RUN cycle; result equals the half-subtractor truth table (`diff=a^b`, `borrow_out=~a&b`).
- Counter width is `$clog2(WIDTH+1)` bits.

## Timing
- Accepted `start` at edge k.
- RUN occupies edges k+1 … k+WIDTH.
- `done` is high in the cycle following edge k+WIDTH.
- Earliest next accepted `start` is at edge k+WIDTH+2, i.e. back in IDLE.
- Latency from accepted `start` to `done`: WIDTH+1 cycles. Throughput: one result per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SERIAL_SUB_SIGNED_EN` defined:
  - Adds the `overflow` output.
  - `overflow` = two's-complement overflow: original `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.
  - Registered at the RUN→DONE edge and held like `diff`.
  - Requires a captured copy of `a[MSB]` and `b[MSB]`.
- Not defined: the `overflow` port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, pulse `start` → `done` 9 cycles later; `diff`=0x1E, `borrow_out`=0, `busy` high for 9 cycles.
- WIDTH=8, a=0x00, b=0x01 → `diff`=0xFF, `borrow_out`=1; with macro, `overflow`=0.
- With macro, WIDTH=8, a=0x80, b=0x01 → `diff`=0x7F, `borrow_out`=0, `overflow`=1.
- Start a=0x10, b=0x01; hold `start`=1 with a=0xFF, b=0xFF throughout RUN → exactly one `done`, `diff`=0x0F; the second request is not executed.
- Assert `rst` asynchronously, between edges, 4 cycles into RUN → all outputs 0 immediately, no `done`; a new start with a=0x03, b=0x05 then gives `diff`=0xFE, `borrow_out`=1.
- WIDTH=1, all four (a,b) combinations → (0,0)→0/0, (0,1)→1/1, (1,0)→1/0, (1,1)→0/0; `done` 2 cycles after `start`.
